// File: rtl/huffman_decoder.sv
// Huffman decoder: bit-serial codeword matching against a host-loaded code
// table. One stream bit per SHIFT/MATCH pair, one symbol per completed
// codeword, and a sticky error when no entry matches within maxCodeLength bits.
module huffman_decoder #(
  parameter int bitInByte     = 7,
  parameter int maxCodeLength = 16,
  parameter int tableDepth    = 16,
  parameter int lengthWidth   = $clog2(maxCodeLength + 1),
  parameter int indexWidth    = $clog2(tableDepth)
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     tableClear,
  input  logic                     tableWrite,
  input  logic [indexWidth-1:0]    tableIndex,
  input  logic [bitInByte:0]       tableSymbol,
  input  logic [maxCodeLength-1:0] tableCode,
  input  logic [lengthWidth-1:0]   tableLength,
  input  logic                     bitIn,
  input  logic                     bitValid,
  output logic                     bitReady,
  output logic [bitInByte:0]       outputData,
  output logic                     dataReady,
  input  logic                     dataAccept,
  output logic                     codeError
);

  typedef enum logic [1:0] {SHIFT, MATCH, OUTPUT, ERROR} state_t;

  state_t                   state;
  logic [maxCodeLength-1:0] acc;
  logic [lengthWidth-1:0]   len;

  logic [bitInByte:0]       tab_symbol [tableDepth];
  logic [maxCodeLength-1:0] tab_code   [tableDepth];
  logic [lengthWidth-1:0]   tab_length [tableDepth];

  logic                     table_we;
  logic                     bit_take;
  logic [maxCodeLength-1:0] len_mask;
  logic                     hit;
  logic [bitInByte:0]       hit_symbol;

  // Handshake and write qualification; writes only land between codewords.
  assign bitReady = (state == SHIFT) && !tableClear && !tableWrite;
  assign bit_take = bitValid && bitReady;
  assign table_we = tableWrite && !tableClear && (state == SHIFT) && (len == '0);

  // Mask selecting the low len bits of the accumulator.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    len_mask = '0;
    for (int i = 0; i < maxCodeLength; i++) len_mask[i] = (i < int'(len));
  end

  // Table lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    hit        = 1'b0;
    hit_symbol = '0;
    for (int e = tableDepth - 1; e >= 0; e--) begin
      if ((tab_length[e] == len) && (tab_length[e] != '0) &&
          (((tab_code[e] ^ acc) & len_mask) == '0)) begin
        hit        = 1'b1;
        hit_symbol = tab_symbol[e];
      end
    end
  end

  // Entry lengths carry validity, so only they are cleared by reset/tableClear.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int e = 0; e < tableDepth; e++) tab_length[e] <= '0;
    end else if (tableClear) begin
      for (int e = 0; e < tableDepth; e++) tab_length[e] <= '0;
    end else if (table_we) begin
      tab_length[tableIndex] <= (int'(tableLength) > maxCodeLength) ? '0 : tableLength;
    end
  end

  // Symbol and code payload storage.
  // NOTE: payload RAM is not reset; a zero length already marks the entry invalid.
  always_ff @(posedge clock) begin
    if (table_we) begin
      tab_symbol[tableIndex] <= tableSymbol;
      tab_code[tableIndex]   <= tableCode;
    end
  end

  // Decode FSM with registered symbol, ready and error outputs.
  always_ff @(posedge clock or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetN) begin
      state      <= SHIFT;
      acc        <= '0;
      len        <= '0;
      outputData <= '0;
      dataReady  <= 1'b0;
      codeError  <= 1'b0;
    end else if (tableClear) begin
      state     <= SHIFT;
      acc       <= '0;
      len       <= '0;
      dataReady <= 1'b0;
      codeError <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (bit_take) begin
            acc   <= {acc[maxCodeLength-2:0], bitIn};
            len   <= len + lengthWidth'(1);
            state <= MATCH;
          end
        end
        MATCH: begin
          if (hit) begin
            outputData <= hit_symbol;
            dataReady  <= 1'b1;
            state      <= OUTPUT;
          end else if (len == lengthWidth'(maxCodeLength)) begin
            codeError <= 1'b1;
            state     <= ERROR;
          end else begin
            state <= SHIFT;
          end
        end
        OUTPUT: begin
          if (dataAccept) begin
            dataReady <= 1'b0;
            acc       <= '0;
            len       <= '0;
            state     <= SHIFT;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: table load, decode, back-pressure,
// error on empty table, overlap priority, write qualification and reset.
module tb_huffman_decoder;

  logic        clock;
  logic        resetN;
  logic        tableClear;
  logic        tableWrite;
  logic [3:0]  tableIndex;
  logic [7:0]  tableSymbol;
  logic [15:0] tableCode;
  logic [4:0]  tableLength;
  logic        bitIn;
  logic        bitValid;
  logic        bitReady;
  logic [7:0]  outputData;
  logic        dataReady;
  logic        dataAccept;
  logic        codeError;

  int checks = 0;
  int errors = 0;
  int ready_rises = 0;

  huffman_decoder dut (
    .clock       (clock),
    .resetN      (resetN),
    .tableClear  (tableClear),
    .tableWrite  (tableWrite),
    .tableIndex  (tableIndex),
    .tableSymbol (tableSymbol),
    .tableCode   (tableCode),
    .tableLength (tableLength),
    .bitIn       (bitIn),
    .bitValid    (bitValid),
    .bitReady    (bitReady),
    .outputData  (outputData),
    .dataReady   (dataReady),
    .dataAccept  (dataAccept),
    .codeError   (codeError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge dataReady) ready_rises++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; writes one entry across the next posedge.
  task automatic write_entry(input logic [3:0] idx, input logic [7:0] sym,
                             input logic [15:0] code, input logic [4:0] len);
    tableWrite  = 1'b1;
    tableIndex  = idx;
    tableSymbol = sym;
    tableCode   = code;
    tableLength = len;
    @(negedge clock);
    tableWrite  = 1'b0;
  endtask

  task automatic clear_table();
    tableClear = 1'b1;
    @(negedge clock);
    tableClear = 1'b0;
  endtask

  task automatic load_basic();
    write_entry(4'd0, 8'h41, 16'd0, 5'd1);
    write_entry(4'd1, 8'h42, 16'd2, 5'd2);
    write_entry(4'd2, 8'h43, 16'd3, 5'd2);
  endtask

  // Called at a negedge; returns at the negedge after the bit is accepted.
  task automatic send_bit(input string tag, input logic b);
    int n;
    n = 0;
    bitIn    = b;
    bitValid = 1'b1;
    #1;
    while (bitReady !== 1'b1 && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({tag, " bitReady"}, bitReady, 1);
    @(posedge clock);
    @(negedge clock);
    bitValid = 1'b0;
  endtask

  task automatic wait_symbol(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (dataReady !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({tag, " dataReady"}, dataReady, 1);
    check({tag, " outputData"}, outputData, exp);
  endtask

  // Sixteen 1-bits into an empty table must error on exactly the 16th.
  task automatic stream_empty_error(input string tag);
    for (int i = 0; i < 16; i++) send_bit(tag, 1'b1);
    check({tag, " no error before 16th match"}, codeError, 0);
    @(negedge clock);
    check({tag, " codeError set"}, codeError, 1);
    check({tag, " bitReady low"}, bitReady, 0);
    bitValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check({tag, " stalled"}, bitReady, 0);
    end
    bitValid = 1'b0;
    tableClear = 1'b1;
    #1;
    check({tag, " bitReady during clear"}, bitReady, 0);
    @(negedge clock);
    tableClear = 1'b0;
    #1;
    check({tag, " codeError cleared"}, codeError, 0);
    check({tag, " bitReady after clear"}, bitReady, 1);
  endtask

  initial begin
    resetN = 1'b0; tableClear = 1'b0; tableWrite = 1'b0; tableIndex = '0;
    tableSymbol = '0; tableCode = '0; tableLength = '0;
    bitIn = 1'b0; bitValid = 1'b0; dataAccept = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    #1;
    check("reset dataReady", dataReady, 0);
    check("reset codeError", codeError, 0);
    check("reset outputData", outputData, 0);
    check("reset bitReady", bitReady, 1);
    @(negedge clock);

    // Basic decode of 1,0,0,1,1 with an always-ready consumer.
    load_basic();
    dataAccept = 1'b1;
    send_bit("t1 b0", 1'b1);
    send_bit("t1 b1", 1'b0);
    wait_symbol("t1 sym0", 8'h42);
    send_bit("t1 b2", 1'b0);
    wait_symbol("t1 sym1", 8'h41);
    send_bit("t1 b3", 1'b1);
    send_bit("t1 b4", 1'b1);
    wait_symbol("t1 sym2", 8'h43);
    @(negedge clock);
    check("t1 dataReady pulse ends", dataReady, 0);
    check("t1 dataReady pulse count", ready_rises, 3);

    // Back-pressure: symbol held, next bit not consumed until accepted.
    dataAccept = 1'b0;
    send_bit("t2 b0", 1'b1);
    send_bit("t2 b1", 1'b0);
    wait_symbol("t2 sym", 8'h42);
    bitIn = 1'b0;
    bitValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("t2 held bitReady", bitReady, 0);
      check("t2 held dataReady", dataReady, 1);
      check("t2 held outputData", outputData, 8'h42);
    end
    dataAccept = 1'b1;
    @(negedge clock);
    dataAccept = 1'b0;
    #1;
    check("t2 bitReady after accept", bitReady, 1);
    check("t2 dataReady after accept", dataReady, 0);
    check("t2 outputData holds", outputData, 8'h42);
    @(posedge clock);
    @(negedge clock);
    bitValid = 1'b0;
    wait_symbol("t2 next sym", 8'h41);
    dataAccept = 1'b1;
    @(negedge clock);

    // Empty table errors after exactly 16 bits; tableClear recovers.
    clear_table();
    stream_empty_error("t3");

    // Overlapping entries: lowest index wins.
    write_entry(4'd0, 8'h11, 16'd1, 5'd1);
    write_entry(4'd3, 8'h33, 16'd1, 5'd1);
    send_bit("t4 b0", 1'b1);
    wait_symbol("t4 sym", 8'h11);
    @(negedge clock);

    // tableWrite collides with bitValid: write wins, bit goes next cycle.
    tableWrite = 1'b1; tableIndex = 4'd1; tableSymbol = 8'h55;
    tableCode = 16'd0; tableLength = 5'd1;
    bitIn = 1'b0; bitValid = 1'b1;
    #1;
    check("t5 bitReady blocked by write", bitReady, 0);
    @(negedge clock);
    tableWrite = 1'b0;
    #1;
    check("t5 bitReady after write", bitReady, 1);
    @(posedge clock);
    @(negedge clock);
    bitValid = 1'b0;
    wait_symbol("t5 written sym", 8'h55);
    @(negedge clock);

    // Writes in MATCH and OUTPUT are ignored.
    dataAccept = 1'b0;
    send_bit("t5 b1", 1'b1);
    tableWrite = 1'b1; tableIndex = 4'd0; tableSymbol = 8'h77;
    tableCode = 16'd1; tableLength = 5'd1;
    @(negedge clock);
    check("t5 match-write sym", outputData, 8'h11);
    tableSymbol = 8'h88;
    @(negedge clock);
    tableWrite = 1'b0;
    dataAccept = 1'b1;
    @(negedge clock);
    send_bit("t5 b2", 1'b1);
    wait_symbol("t5 ignored writes", 8'h11);
    @(negedge clock);

    // Reset mid-codeword clears state and the table.
    clear_table();
    load_basic();
    send_bit("t6 b0", 1'b1);
    resetN = 1'b0;
    #1;
    check("t6 reset dataReady", dataReady, 0);
    check("t6 reset codeError", codeError, 0);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    check("t6 reset bitReady", bitReady, 1);
    @(negedge clock);
    stream_empty_error("t6 empty");
    @(negedge clock);
    load_basic();
    send_bit("t6 b1", 1'b1);
    send_bit("t6 b2", 1'b0);
    wait_symbol("t6 sym", 8'h42);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
